// File: rtl/dcache_pkg.sv
// Shared geometry constants and FSM state type for the direct-mapped data cache.
package dcache_pkg;

    localparam int TAG_W = 20;
    localparam int IDX_W = 8;
    localparam int OFS_W = 4;
    localparam int SETS  = 256;
    localparam int WORDS = 4;

    // Burst type code for a whole-line transfer on the bridge side.
    localparam logic [2:0] LINE_TYPE = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WBACK,
        S_RDREQ,
        S_REFILL,
        S_RESP
    } state_e;

endpackage

// File: rtl/dcache_merge.sv
// Combinational byte merge: bytes enabled in wstrb come from wdata, the rest from old.
module dcache_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] merged_o
);

    // Select each byte lane independently from the write data or the old word.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged_o[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : old_i[8*b +: 8];
        end
    end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache: 256 sets x 16-byte lines.
// Serves one blocking CPU request at a time and refills/evicts whole lines.
module dcache_dm
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    // CPU-side request channel
    input  logic               data_valid,
    input  logic               data_op,
    input  logic [IDX_W-1:0]   data_index,
    input  logic [TAG_W-1:0]   data_tag,
    input  logic [OFS_W-1:0]   data_offset,
    input  logic [3:0]         data_wstrb,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,
    // Line refill channel
    output logic               rd_req,
    output logic [2:0]         rd_type,
    output logic [31:0]        rd_addr,
    input  logic               rd_rdy,
    input  logic               ret_valid,
    input  logic               ret_last,
    input  logic [31:0]        ret_data,
    // Line write-back channel
    output logic               wr_req,
    output logic [2:0]         wr_type,
    output logic [31:0]        wr_addr,
    output logic [3:0]         wr_wstrb,
    output logic [127:0]       wr_data,
    input  logic               wr_rdy
);

    state_e state_q, state_d;

    // Latched request; only the word-select bits of the offset matter because
    // write data arrives already lane-aligned.
    logic               req_op_q;
    logic [IDX_W-1:0]   req_idx_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [1:0]         req_word_q;
    logic [3:0]         req_wstrb_q;
    logic [31:0]        req_wdata_q;
    logic               unused_ofs;

    logic [1:0]         cnt_q;
    logic [31:0]        resp_q;

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [31:0]        data_arr [SETS][WORDS];

    logic               hit;
    logic               victim_dirty;
    logic [31:0]        hit_word;
    logic [31:0]        merge_old;
    logic [31:0]        merged;

    logic               arr_we;
    logic [1:0]         arr_word;
    logic [31:0]        arr_wdata;
    logic               line_fill;
    logic               set_dirty;

    assign unused_ofs = ^data_offset[1:0];

    assign rd_type  = LINE_TYPE;
    assign wr_type  = LINE_TYPE;
    assign wr_wstrb = 4'hf;

    assign hit_word     = data_arr[req_idx_q][req_word_q];
    assign hit          = valid_q[req_idx_q] && (tag_arr[req_idx_q] == req_tag_q);
    assign victim_dirty = valid_q[req_idx_q] && dirty_q[req_idx_q];

    // A write hit merges into the stored word; a write miss merges into the refill beat.
    assign merge_old = (state_q == S_REFILL) ? ret_data : hit_word;

    dcache_merge u_merge (
        .old_i    (merge_old),
        .wdata_i  (req_wdata_q),
        .wstrb_i  (req_wstrb_q),
        .merged_o (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of block order.
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state, handshake outputs and array write controls.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a signal unassigned, which would infer a latch.
        state_d      = state_q;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        arr_we       = 1'b0;
        arr_word     = '0;
        arr_wdata    = '0;
        line_fill    = 1'b0;
        set_dirty    = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_addr_ok = 1'b1;
                if (data_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    data_data_ok = 1'b1;
                    data_rdata   = hit_word;
                    if (req_op_q) begin
                        arr_we    = 1'b1;
                        arr_word  = req_word_q;
                        arr_wdata = merged;
                        set_dirty = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (victim_dirty) begin
                    state_d = S_WBACK;
                end else begin
                    state_d = S_RDREQ;
                end
            end
            S_WBACK: begin
                wr_req  = 1'b1;
                wr_addr = {tag_arr[req_idx_q], req_idx_q, 4'b0};
                wr_data = {data_arr[req_idx_q][3], data_arr[req_idx_q][2],
                           data_arr[req_idx_q][1], data_arr[req_idx_q][0]};
                if (wr_rdy) state_d = S_RDREQ;
            end
            S_RDREQ: begin
                rd_req  = 1'b1;
                rd_addr = {req_tag_q, req_idx_q, 4'b0};
                if (rd_rdy) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (ret_valid) begin
                    arr_we    = 1'b1;
                    arr_word  = cnt_q;
                    arr_wdata = (req_op_q && cnt_q == req_word_q) ? merged : ret_data;
                    if (ret_last) begin
                        line_fill = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                data_data_ok = 1'b1;
                data_rdata   = resp_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_op_q    <= 1'b0;
            req_idx_q   <= '0;
            req_tag_q   <= '0;
            req_word_q  <= '0;
            req_wstrb_q <= '0;
            req_wdata_q <= '0;
        end else if (state_q == S_IDLE && data_valid) begin
            req_op_q    <= data_op;
            req_idx_q   <= data_index;
            req_tag_q   <= data_tag;
            req_word_q  <= data_offset[3:2];
            req_wstrb_q <= data_wstrb;
            req_wdata_q <= data_wdata;
        end
    end

    // Refill beat counter and capture of the requested word for the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            resp_q <= '0;
        end else if (state_q == S_RDREQ && rd_rdy) begin
            cnt_q <= '0;
        end else if (state_q == S_REFILL && ret_valid) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == req_word_q) resp_q <= ret_data;
        end
    end

    // Line valid/dirty flags: cleared on reset, set on line fill or write hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_fill) begin
            valid_q[req_idx_q] <= 1'b1;
            dirty_q[req_idx_q] <= req_op_q;
        end else if (set_dirty) begin
            dirty_q[req_idx_q] <= 1'b1;
        end
    end

    // Tag and data storage.
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; the cleared valid bits make their
        // contents irrelevant, and leaving them unreset keeps them plain storage.
        if (arr_we)    data_arr[req_idx_q][arr_word] <= arr_wdata;
        if (line_fill) tag_arr[req_idx_q]            <= req_tag_q;
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed self-checking bench for dcache_dm: misses, hits, write merge,
// dirty eviction, stalled refill handshake and reset during a refill.
module tb_dcache_dm;

    logic         clk = 1'b0;
    logic         reset;
    logic         data_valid, data_op;
    logic [7:0]   data_index;
    logic [19:0]  data_tag;
    logic [3:0]   data_offset, data_wstrb;
    logic [31:0]  data_wdata;
    logic         data_addr_ok, data_data_ok;
    logic [31:0]  data_rdata;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, ret_data, wr_addr;
    logic         wr_req, wr_rdy;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    dcache_dm dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid   (data_valid),
        .data_op      (data_op),
        .data_index   (data_index),
        .data_tag     (data_tag),
        .data_offset  (data_offset),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rd_req       (rd_req),
        .rd_type      (rd_type),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data),
        .wr_req       (wr_req),
        .wr_type      (wr_type),
        .wr_addr      (wr_addr),
        .wr_wstrb     (wr_wstrb),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_addr_ok"}, data_addr_ok, 1'b1);
        check({pfx, "_data_ok"}, data_data_ok, 1'b0);
        check({pfx, "_rd_req"},  rd_req,       1'b0);
        check({pfx, "_wr_req"},  wr_req,       1'b0);
        check({pfx, "_rdata"},   data_rdata,   32'h0);
        check({pfx, "_rd_addr"}, rd_addr,      32'h0);
        check({pfx, "_wr_addr"}, wr_addr,      32'h0);
        check({pfx, "_wr_data"}, wr_data,      128'h0);
        check({pfx, "_rd_type"}, rd_type,      3'b100);
        check({pfx, "_wr_type"}, wr_type,      3'b100);
        check({pfx, "_wstrb"},   wr_wstrb,     4'hf);
    endtask

    // Present a request in IDLE; returns #1 after the accepting edge.
    task automatic do_req(input logic op, input logic [19:0] tag, input logic [7:0] idx,
                          input logic [3:0] ofs, input logic [3:0] strb, input logic [31:0] wd);
        @(negedge clk);
        data_op     = op;
        data_tag    = tag;
        data_index  = idx;
        data_offset = ofs;
        data_wstrb  = strb;
        data_wdata  = wd;
        data_valid  = 1'b1;
        check("addr_ok_at_accept", data_addr_ok, 1'b1);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    // Wait (bounded) for rd_req or wr_req; returns at the negedge where it is seen.
    task automatic wait_req(input bit want_wr);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((want_wr ? wr_req : rd_req) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(want_wr ? "wr_req_seen" : "rd_req_seen", seen, 1'b1);
    endtask

    // Wait (bounded) for data_data_ok; reports latency in cycles from the call.
    task automatic wait_data_ok(output logic [31:0] rd, output int cycles);
        cycles = -1;
        rd     = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (data_data_ok === 1'b1) begin
                cycles = i;
                rd     = data_rdata;
                break;
            end
        end
        check("data_ok_seen", cycles >= 0, 1'b1);
    endtask

    // Accept the pending request (called at a negedge).
    task automatic handshake(input bit is_wr);
        if (is_wr) wr_rdy = 1'b1;
        else       rd_rdy = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        rd_rdy = 1'b0;
    endtask

    // Send n refill beats back to back, word 0 first, last flag on word 3.
    task automatic send_beats(input logic [127:0] line, input int n);
        for (int i = 0; i < n; i++) begin
            ret_valid = 1'b1;
            ret_data  = line[32*i +: 32];
            ret_last  = (i == 3);
            @(posedge clk); #1;
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;

        reset = 1'b1;
        data_valid = 1'b0; data_op = 1'b0; data_index = '0; data_tag = '0;
        data_offset = '0; data_wstrb = '0; data_wdata = '0;
        rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Cold read miss, clean victim.
        do_req(1'b0, 20'hABCDE, 8'h12, 4'h4, 4'h0, 32'h0);
        wait_req(1'b0);
        check("miss1_rd_addr", rd_addr, 32'hABCDE120);
        check("miss1_addr_ok", data_addr_ok, 1'b0);
        check("miss1_no_wr",   wr_req, 1'b0);
        handshake(1'b0);
        send_beats(128'h00000044_00000033_00000022_00000011, 4);
        wait_data_ok(rd, lat);
        check("miss1_latency", lat, 0);
        check("miss1_rdata",   rd, 32'h00000022);

        // Read hit in another word of the same line.
        do_req(1'b0, 20'hABCDE, 8'h12, 4'hC, 4'h0, 32'h0);
        @(negedge clk);
        check("hit_data_ok",   data_data_ok, 1'b1);
        check("hit_rdata",     data_rdata, 32'h00000044);
        check("hit_no_rd_req", rd_req, 1'b0);
        check("hit_addr_ok",   data_addr_ok, 1'b0);

        // Write hit with a single byte lane, then read back the merged word.
        do_req(1'b1, 20'hABCDE, 8'h12, 4'h4, 4'b0010, 32'h0000AA00);
        @(negedge clk);
        check("whit_data_ok",  data_data_ok, 1'b1);
        check("whit_no_rd",    rd_req, 1'b0);
        do_req(1'b0, 20'hABCDE, 8'h12, 4'h4, 4'h0, 32'h0);
        @(negedge clk);
        check("rdback_data_ok", data_data_ok, 1'b1);
        check("rdback_rdata",   data_rdata, 32'h0000AA22);

        // Conflict miss on a dirty line: write-back first.
        do_req(1'b0, 20'h12345, 8'h12, 4'h0, 4'h0, 32'h0);
        wait_req(1'b1);
        check("wb_addr",   wr_addr, 32'hABCDE120);
        check("wb_data",   wr_data, 128'h00000044_00000033_0000AA22_00000011);
        check("wb_wstrb",  wr_wstrb, 4'hf);
        check("wb_no_rd",  rd_req, 1'b0);
        @(negedge clk);
        check("wb_hold_req",  wr_req, 1'b1);
        check("wb_hold_addr", wr_addr, 32'hABCDE120);
        handshake(1'b1);
        @(negedge clk);
        check("after_wb_rd_req", rd_req, 1'b1);
        check("after_wb_wr_req", wr_req, 1'b0);
        check("after_wb_rd_addr", rd_addr, 32'h12345120);

        // Stall the refill request; a valid offered meanwhile must not be taken.
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'b1;
            data_op    = 1'b1;
            data_tag   = 20'h55555;
            check("stall_rd_req",  rd_req, 1'b1);
            check("stall_rd_addr", rd_addr, 32'h12345120);
            check("stall_addr_ok", data_addr_ok, 1'b0);
            @(negedge clk);
        end
        data_valid = 1'b0;
        data_op    = 1'b0;
        handshake(1'b0);
        send_beats(128'h000000D4_000000D3_000000D2_000000D1, 2);

        // Reset in the middle of the refill.
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;

        // Same address misses again; the old dirty line was invalidated, so no write-back.
        do_req(1'b0, 20'h12345, 8'h12, 4'h0, 4'h0, 32'h0);
        wait_req(1'b0);
        check("rerd_rd_addr", rd_addr, 32'h12345120);
        check("rerd_no_wr",   wr_req, 1'b0);
        handshake(1'b0);
        send_beats(128'h00000054_00000053_00000052_00000051, 4);
        wait_data_ok(rd, lat);
        check("rerd_latency", lat, 0);
        check("rerd_rdata",   rd, 32'h00000051);

        // Write miss: the matching refill beat is merged and the line becomes dirty.
        do_req(1'b1, 20'h12345, 8'h34, 4'h8, 4'b1100, 32'hBEEF0000);
        wait_req(1'b0);
        check("wmiss_rd_addr", rd_addr, 32'h12345340);
        handshake(1'b0);
        send_beats(128'h00000103_00000102_00000101_00000100, 4);
        wait_data_ok(rd, lat);
        check("wmiss_latency", lat, 0);
        do_req(1'b0, 20'h12345, 8'h34, 4'h8, 4'h0, 32'h0);
        @(negedge clk);
        check("wmiss_rdback_ok", data_data_ok, 1'b1);
        check("wmiss_rdback",    data_rdata, 32'hBEEF0102);

        // Evict the write-allocated line.
        do_req(1'b0, 20'h0F0F0, 8'h34, 4'h0, 4'h0, 32'h0);
        wait_req(1'b1);
        check("wb2_addr", wr_addr, 32'h12345340);
        check("wb2_data", wr_data, 128'h00000103_BEEF0102_00000101_00000100);
        handshake(1'b1);
        @(negedge clk);
        check("wb2_rd_addr", rd_addr, 32'h0F0F0340);
        handshake(1'b0);
        send_beats(128'h0000000A_00000009_00000008_00000007, 4);
        wait_data_ok(rd, lat);
        check("wb2_rdata", rd, 32'h00000007);

        // Stray handshakes and beats in IDLE are ignored.
        @(negedge clk);
        rd_rdy = 1'b1; wr_rdy = 1'b1; ret_valid = 1'b1; ret_data = 32'hDEADBEEF;
        @(negedge clk);
        check("stray_addr_ok", data_addr_ok, 1'b1);
        check("stray_rd_req",  rd_req, 1'b0);
        rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_data = '0;
        do_req(1'b0, 20'h0F0F0, 8'h34, 4'h4, 4'h0, 32'h0);
        @(negedge clk);
        check("stray_hit_ok",    data_data_ok, 1'b1);
        check("stray_hit_rdata", data_rdata, 32'h00000008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
